// File: rtl/ckpt_rat_pkg.sv
// Shared types for the ROB-tagged rename table: table entry, branch checkpoint,
// and modulo-ROB robid helpers (add with wrap, age relative to the ROB head).
package ckpt_rat_pkg;

    localparam int RAT_ARCH_REGS = 32;
    localparam int RAT_ROB_DEPTH = 64;
    localparam int RAT_ROB_W     = $clog2(RAT_ROB_DEPTH);

    typedef struct packed {
        logic                 inrob;
        logic [RAT_ROB_W-1:0] tag;
    } rat_entry_t;

    typedef rat_entry_t [RAT_ARCH_REGS-1:0] rat_tbl_t;

    typedef struct packed {
        logic                 valid;
        logic [RAT_ROB_W-1:0] robid;
        rat_tbl_t             snap;
    } ckpt_t;

    function automatic logic [RAT_ROB_W-1:0] rob_add(input logic [RAT_ROB_W-1:0] base,
                                                     input logic [RAT_ROB_W-1:0] off);
        logic [RAT_ROB_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= RAT_ROB_DEPTH[RAT_ROB_W:0])
            sum = sum - RAT_ROB_DEPTH[RAT_ROB_W:0];
        return sum[RAT_ROB_W-1:0];
    endfunction

    // Distance from the oldest in-flight robid; larger means younger.
    function automatic logic [RAT_ROB_W-1:0] rob_age(input logic [RAT_ROB_W-1:0] robid,
                                                     input logic [RAT_ROB_W-1:0] head);
        logic [RAT_ROB_W:0] diff;
        diff = {1'b0, robid} + RAT_ROB_DEPTH[RAT_ROB_W:0] - {1'b0, head};
        if (diff >= RAT_ROB_DEPTH[RAT_ROB_W:0])
            diff = diff - RAT_ROB_DEPTH[RAT_ROB_W:0];
        return diff[RAT_ROB_W-1:0];
    endfunction

endpackage

// File: rtl/ckpt_rat_age_cmp.sv
// Marks every valid checkpoint strictly younger than the referenced one.
// Purely combinational; no flow control.
module ckpt_age_cmp
    import ckpt_rat_pkg::*;
#(
    parameter int NUM_CKPT = 4,
    parameter int CK_W     = $clog2(NUM_CKPT)
) (
    input  logic [RAT_ROB_W-1:0]               i_rob_head,
    input  logic [NUM_CKPT-1:0]                i_ck_valid,
    input  logic [NUM_CKPT-1:0][RAT_ROB_W-1:0] i_ck_robid,
    input  logic [CK_W-1:0]                    i_ref_idx,
    output logic [NUM_CKPT-1:0]                o_younger
);

    logic [RAT_ROB_W-1:0] w_ref_age;

    always_comb begin
        w_ref_age = rob_age(i_ck_robid[i_ref_idx], i_rob_head);
        for (int k = 0; k < NUM_CKPT; k++)
            o_younger[k] = i_ck_valid[k] && (rob_age(i_ck_robid[k], i_rob_head) > w_ref_age);
    end

endmodule

// File: rtl/ckpt_rat.sv
// Rename table mapping arch regs to {in-ROB, robid} with branch checkpoints and retire clears.
// Latency 1 cycle (registered rename outputs); grp_ready drops on a mispredict or a branch with no free checkpoint.
module ckpt_rat
    import ckpt_rat_pkg::*;
#(
    parameter int ARCH_REGS = RAT_ARCH_REGS,
    parameter int ISSUE_W   = 2,
    parameter int RET_W     = 2,
    parameter int ROB_DEPTH = RAT_ROB_DEPTH,
    parameter int NUM_CKPT  = 4,
    localparam int ROB_W    = $clog2(ROB_DEPTH),
    localparam int CK_W     = $clog2(NUM_CKPT),
    localparam int REG_W    = $clog2(ARCH_REGS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 grp_valid,
    output logic                                 grp_ready,
    input  logic [ISSUE_W-1:0]                   slot_val,
    input  logic [ISSUE_W-1:0]                   slot_wr,
    input  logic [ISSUE_W-1:0]                   slot_br,
    input  logic [ISSUE_W-1:0][REG_W-1:0]        rd,
    input  logic [ISSUE_W-1:0][REG_W-1:0]        rs1,
    input  logic [ISSUE_W-1:0][REG_W-1:0]        rs2,
    input  logic [ROB_W-1:0]                     rob_base,
    input  logic [ROB_W-1:0]                     rob_head,
    input  logic [RET_W-1:0]                     ret_val,
    input  logic [RET_W-1:0]                     ret_wr,
    input  logic [RET_W-1:0][REG_W-1:0]          ret_rd,
    input  logic [RET_W-1:0][ROB_W-1:0]          ret_robid,
    input  logic                                 res_val,
    input  logic [CK_W-1:0]                      res_ckpt,
    input  logic                                 res_mispred,
    output logic                                 ren_valid,
    output logic [ISSUE_W-1:0][1:0][ROB_W-1:0]   ren_tag,
    output logic [ISSUE_W-1:0][1:0]              ren_inrob,
    output logic [CK_W-1:0]                      ren_ckpt,
    output logic [CK_W:0]                        ckpt_free
);

    rat_tbl_t r_table;
    ckpt_t    r_ckpt [NUM_CKPT];

    logic                               w_any_br, w_res_hit, w_mispred, w_release, w_accept;
    logic                               w_do_alloc;
    logic [CK_W-1:0]                    w_alloc_idx;
    logic [NUM_CKPT-1:0]                w_ck_valid, w_younger, w_free_mask, w_alloc_oh;
    logic [NUM_CKPT-1:0][ROB_W-1:0]     w_ck_robid;
    logic [ISSUE_W-1:0][ROB_W-1:0]      w_slot_robid;
    logic [ROB_W-1:0]                   w_br_robid;
    rat_tbl_t                           w_tab_clr, w_tab_nxt, w_snap_new;
    rat_tbl_t                           w_ck_clr [NUM_CKPT];
    logic [ISSUE_W-1:0][1:0][ROB_W-1:0] w_src_tag;
    logic [ISSUE_W-1:0][1:0]            w_src_inrob;

    // A retire only clears the entry still pointing at the retiring robid; the tag stays for PRF lookup.
    function automatic rat_tbl_t apply_clears(input rat_tbl_t tbl);
        rat_tbl_t res;
        res = tbl;
        for (int p = 0; p < RET_W; p++)
            if (ret_val[p] && ret_wr[p] && (ret_rd[p] != '0) &&
                (tbl[ret_rd[p]] == {1'b1, ret_robid[p]}))
                res[ret_rd[p]].inrob = 1'b0;
        return res;
    endfunction

    always_comb begin
        ckpt_free = '0;
        for (int k = 0; k < NUM_CKPT; k++) begin
            w_ck_valid[k] = r_ckpt[k].valid;
            w_ck_robid[k] = r_ckpt[k].robid;
            w_ck_clr[k]   = apply_clears(r_ckpt[k].snap);
            if (!r_ckpt[k].valid)
                ckpt_free = ckpt_free + (CK_W+1)'(1);
        end
    end

    ckpt_age_cmp #(.NUM_CKPT(NUM_CKPT), .CK_W(CK_W)) u_age_cmp (
        .i_rob_head (rob_head),
        .i_ck_valid (w_ck_valid),
        .i_ck_robid (w_ck_robid),
        .i_ref_idx  (res_ckpt),
        .o_younger  (w_younger)
    );

    always_comb begin
        w_any_br   = |slot_br;
        w_res_hit  = res_val && w_ck_valid[res_ckpt];
        w_mispred  = w_res_hit && res_mispred;
        w_release  = w_res_hit && !res_mispred;
        grp_ready  = !(w_any_br && (ckpt_free == '0)) && !(res_val && res_mispred);
        w_accept   = grp_valid && grp_ready;
        w_do_alloc = w_accept && w_any_br;

        // Lowest free index from the current state, so a same-cycle release is never reused.
        w_alloc_idx = '0;
        for (int k = NUM_CKPT-1; k >= 0; k--)
            if (!w_ck_valid[k])
                w_alloc_idx = CK_W'(k);
        w_alloc_oh = w_do_alloc ? (NUM_CKPT'(1) << w_alloc_idx) : '0;

        w_free_mask = '0;
        if (w_release)
            w_free_mask = NUM_CKPT'(1) << res_ckpt;
        if (w_mispred)
            w_free_mask = (NUM_CKPT'(1) << res_ckpt) | w_younger;
    end

    always_comb begin
        w_tab_clr  = apply_clears(r_table);
        w_tab_nxt  = w_tab_clr;
        w_snap_new = w_tab_clr;
        w_br_robid = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_slot_robid[i] = rob_add(rob_base, ROB_W'(i));
            if (slot_val[i] && slot_wr[i] && (rd[i] != '0))
                w_tab_nxt[rd[i]] = '{inrob: 1'b1, tag: w_slot_robid[i]};
            if (slot_br[i]) begin
                w_snap_new = w_tab_nxt;
                w_br_robid = w_slot_robid[i];
            end
        end
    end

    always_comb begin
        logic [REG_W-1:0] w_idx;
        rat_entry_t       w_ent;
        for (int i = 0; i < ISSUE_W; i++) begin
            for (int s = 0; s < 2; s++) begin
                w_idx = (s == 0) ? rs1[i] : rs2[i];
                w_ent = r_table[w_idx];
                for (int j = 0; j < i; j++)
                    if (slot_val[j] && slot_wr[j] && (rd[j] == w_idx))
                        w_ent = '{inrob: 1'b1, tag: w_slot_robid[j]};
                if (w_idx == '0)
                    w_ent = '0;
                w_src_inrob[i][s] = w_ent.inrob;
                w_src_tag[i][s]   = w_ent.tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_table   <= '0;
            for (int k = 0; k < NUM_CKPT; k++)
                r_ckpt[k] <= '0;
            ren_valid <= 1'b0;
            ren_tag   <= '0;
            ren_inrob <= '0;
            ren_ckpt  <= '0;
        end else begin
            if (w_mispred)
                r_table <= w_ck_clr[res_ckpt];
            else if (w_accept)
                r_table <= w_tab_nxt;
            else
                r_table <= w_tab_clr;

            for (int k = 0; k < NUM_CKPT; k++) begin
                if (w_alloc_oh[k]) begin
                    r_ckpt[k] <= '{valid: 1'b1, robid: w_br_robid, snap: w_snap_new};
                end else begin
                    r_ckpt[k].valid <= r_ckpt[k].valid && !w_free_mask[k];
                    r_ckpt[k].snap  <= w_ck_clr[k];
                end
            end

            ren_valid <= w_accept;
            if (w_accept) begin
                ren_tag   <= w_src_tag;
                ren_inrob <= w_src_inrob;
                ren_ckpt  <= w_any_br ? w_alloc_idx : '0;
            end
        end
    end

endmodule

// File: tb/tb_ckpt_rat.sv
// Bench for ckpt_rat: directed scenarios plus randomized traffic against a behavioural rename model.
module tb_ckpt_rat;

    logic              clk = 1'b0;
    logic              rst;
    logic              grp_valid, grp_ready;
    logic [1:0]        slot_val, slot_wr, slot_br;
    logic [1:0][4:0]   rd, rs1, rs2;
    logic [5:0]        rob_base, rob_head;
    logic [1:0]        ret_val, ret_wr;
    logic [1:0][4:0]   ret_rd;
    logic [1:0][5:0]   ret_robid;
    logic              res_val, res_mispred;
    logic [1:0]        res_ckpt;
    logic              ren_valid;
    logic [1:0][1:0][5:0] ren_tag;
    logic [1:0][1:0]   ren_inrob;
    logic [1:0]        ren_ckpt;
    logic [2:0]        ckpt_free;

    always #5 clk = ~clk;

    ckpt_rat dut (
        .clk(clk), .rst(rst), .grp_valid(grp_valid), .grp_ready(grp_ready),
        .slot_val(slot_val), .slot_wr(slot_wr), .slot_br(slot_br),
        .rd(rd), .rs1(rs1), .rs2(rs2), .rob_base(rob_base), .rob_head(rob_head),
        .ret_val(ret_val), .ret_wr(ret_wr), .ret_rd(ret_rd), .ret_robid(ret_robid),
        .res_val(res_val), .res_ckpt(res_ckpt), .res_mispred(res_mispred),
        .ren_valid(ren_valid), .ren_tag(ren_tag), .ren_inrob(ren_inrob),
        .ren_ckpt(ren_ckpt), .ckpt_free(ckpt_free)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural map and checkpoint copies as plain integer arrays.
    int m_in[32], m_tg[32];
    bit m_cv[4];
    int m_crob[4];
    int m_cin[4][32], m_ctg[4][32];
    bit e_ready, obs_ready, e_valid;
    int e_in[2][2], e_tg[2][2];
    int e_ck;

    function automatic int free_cnt();
        int n = 0;
        for (int k = 0; k < 4; k++) if (!m_cv[k]) n++;
        return n;
    endfunction

    function automatic int age(int id, int head);
        return (id - head + 64) % 64;
    endfunction

    task automatic tick();
        int acc, bslot, fidx, a, r, t, rc, ra;
        #2;
        obs_ready = grp_ready;
        e_ready = !((slot_br != 0) && free_cnt() == 0) && !(res_val && res_mispred);
        acc = grp_valid && e_ready;
        bslot = -1;
        fidx = -1;
        if (rst) begin
            for (int q = 0; q < 32; q++) begin m_in[q] = 0; m_tg[q] = 0; end
            for (int k = 0; k < 4; k++) m_cv[k] = 0;
            for (int i = 0; i < 2; i++) for (int s = 0; s < 2; s++) begin e_in[i][s] = 0; e_tg[i][s] = 0; end
            e_ck = 0;
            e_valid = 0;
        end else begin
            if (acc) begin
                for (int i = 0; i < 2; i++) for (int s = 0; s < 2; s++) begin
                    a = (s == 0) ? rs1[i] : rs2[i];
                    e_in[i][s] = m_in[a];
                    e_tg[i][s] = m_tg[a];
                    for (int j = 0; j < i; j++)
                        if (slot_val[j] && slot_wr[j] && rd[j] == a) begin
                            e_in[i][s] = 1;
                            e_tg[i][s] = (rob_base + j) % 64;
                        end
                    if (a == 0) begin e_in[i][s] = 0; e_tg[i][s] = 0; end
                end
                for (int i = 0; i < 2; i++) if (slot_br[i]) bslot = i;
                for (int k = 3; k >= 0; k--) if (!m_cv[k]) fidx = k;
                e_ck = (bslot >= 0) ? fidx : 0;
            end
            e_valid = acc;
            for (int p = 0; p < 2; p++) begin
                if (ret_val[p] && ret_wr[p] && ret_rd[p] != 0) begin
                    r = ret_rd[p];
                    t = ret_robid[p];
                    if (m_in[r] == 1 && m_tg[r] == t) m_in[r] = 0;
                    for (int k = 0; k < 4; k++)
                        if (m_cin[k][r] == 1 && m_ctg[k][r] == t) m_cin[k][r] = 0;
                end
            end
            if (res_val && m_cv[res_ckpt] && res_mispred) begin
                rc = res_ckpt;
                ra = age(m_crob[rc], rob_head);
                for (int q = 0; q < 32; q++) begin m_in[q] = m_cin[rc][q]; m_tg[q] = m_ctg[rc][q]; end
                for (int k = 0; k < 4; k++)
                    if (m_cv[k] && age(m_crob[k], rob_head) > ra) m_cv[k] = 0;
                m_cv[rc] = 0;
            end else begin
                if (res_val && m_cv[res_ckpt]) m_cv[res_ckpt] = 0;
                if (acc) begin
                    for (int i = 0; i < 2; i++) begin
                        if (slot_val[i] && slot_wr[i] && rd[i] != 0) begin
                            m_in[rd[i]] = 1;
                            m_tg[rd[i]] = (rob_base + i) % 64;
                        end
                        if (i == bslot) begin
                            for (int q = 0; q < 32; q++) begin m_cin[fidx][q] = m_in[q]; m_ctg[fidx][q] = m_tg[q]; end
                            m_cv[fidx] = 1;
                            m_crob[fidx] = (rob_base + i) % 64;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        grp_valid = 0; slot_val = '0; slot_wr = '0; slot_br = '0;
        rd = '0; rs1 = '0; rs2 = '0; rob_base = '0; rob_head = '0;
        ret_val = '0; ret_wr = '0; ret_rd = '0; ret_robid = '0;
        res_val = 0; res_ckpt = '0; res_mispred = 0;
    endtask

    task automatic set_slot(input int i, input bit v, input bit w, input bit b,
                            input int d, input int a, input int c);
        slot_val[i] = v; slot_wr[i] = w; slot_br[i] = b;
        rd[i] = 5'(d); rs1[i] = 5'(a); rs2[i] = 5'(c);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ren_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", ren_valid); end
        checks++; if (ckpt_free !== 3'd4) begin errors++; $display("FAIL reset_free got %0d want 4", ckpt_free); end
        checks++; if (ren_tag !== '0 || ren_inrob !== '0 || ren_ckpt !== '0) begin
            errors++; $display("FAIL reset_outs got tag=%h inrob=%b ck=%0d want 0", ren_tag, ren_inrob, ren_ckpt); end
        checks++; if (grp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0d want 1", grp_ready); end
        grp_valid = 1; set_slot(0, 1, 0, 0, 0, 5, 0);
        tick();
        checks++; if (ren_valid !== 1'b1 || ren_inrob[0][0] !== 1'b0 || ren_tag[0][0] !== 6'd0) begin
            errors++; $display("FAIL first_lookup got v=%0d {%0d,%0d} want v=1 {0,0}", ren_valid, ren_inrob[0][0], ren_tag[0][0]); end
        checks++; if (ckpt_free !== 3'd4) begin errors++; $display("FAIL first_free got %0d want 4", ckpt_free); end
    endtask

    task automatic test_bypass();
        do_reset();
        grp_valid = 1; rob_base = 10;
        set_slot(0, 1, 1, 0, 3, 0, 0); set_slot(1, 1, 0, 0, 0, 3, 0);
        tick();
        checks++; if (ren_inrob[1][0] !== 1'b1 || ren_tag[1][0] !== 6'd10) begin
            errors++; $display("FAIL bypass got {%0d,%0d} want {1,10}", ren_inrob[1][0], ren_tag[1][0]); end
        rob_base = 12;
        set_slot(0, 1, 0, 0, 0, 3, 0); set_slot(1, 1, 0, 0, 0, 0, 3);
        tick();
        checks++; if (ren_inrob[0][0] !== 1'b1 || ren_tag[0][0] !== 6'd10 || ren_inrob[1][1] !== 1'b1 || ren_tag[1][1] !== 6'd10) begin
            errors++; $display("FAIL table_after_write got {%0d,%0d} {%0d,%0d} want {1,10}", ren_inrob[0][0], ren_tag[0][0], ren_inrob[1][1], ren_tag[1][1]); end
    endtask

    task automatic test_retire_override();
        do_reset();
        grp_valid = 1; rob_base = 12; set_slot(0, 1, 1, 0, 7, 0, 0);
        ret_val = 2'b01; ret_wr = 2'b01; ret_rd[0] = 7; ret_robid[0] = 4;
        tick();
        ret_val = '0; rob_base = 14; set_slot(0, 1, 0, 0, 0, 7, 0);
        tick();
        checks++; if (ren_inrob[0][0] !== 1'b1 || ren_tag[0][0] !== 6'd12) begin
            errors++; $display("FAIL issue_over_retire got {%0d,%0d} want {1,12}", ren_inrob[0][0], ren_tag[0][0]); end
        grp_valid = 0; ret_val = 2'b01; ret_robid[0] = 12;
        tick();
        ret_val = '0; grp_valid = 1; rob_base = 16;
        tick();
        checks++; if (ren_inrob[0][0] !== 1'b0 || ren_tag[0][0] !== 6'd12) begin
            errors++; $display("FAIL retire_clear got {%0d,%0d} want {0,12}", ren_inrob[0][0], ren_tag[0][0]); end
    endtask

    task automatic test_mispredict();
        do_reset();
        grp_valid = 1; rob_base = 18; set_slot(0, 1, 1, 0, 8, 0, 0);
        tick();
        rob_base = 20; set_slot(0, 1, 0, 1, 0, 0, 0);
        tick();
        checks++; if (ren_ckpt !== 2'd0 || ckpt_free !== 3'd3) begin
            errors++; $display("FAIL br_alloc got ck=%0d free=%0d want ck=0 free=3", ren_ckpt, ckpt_free); end
        rob_base = 22; set_slot(0, 1, 1, 0, 8, 0, 0);
        tick();
        rob_base = 26; res_val = 1; res_ckpt = 0; res_mispred = 1;
        #1;
        checks++; if (grp_ready !== 1'b0) begin errors++; $display("FAIL mispred_ready got %0d want 0", grp_ready); end
        tick();
        checks++; if (ren_valid !== 1'b0 || ckpt_free !== 3'd4) begin
            errors++; $display("FAIL mispred_state got v=%0d free=%0d want v=0 free=4", ren_valid, ckpt_free); end
        res_val = 0; set_slot(0, 1, 0, 0, 0, 8, 0);
        tick();
        checks++; if (ren_inrob[0][0] !== 1'b1 || ren_tag[0][0] !== 6'd18) begin
            errors++; $display("FAIL restore got {%0d,%0d} want {1,18}", ren_inrob[0][0], ren_tag[0][0]); end
    endtask

    task automatic test_ckpt_full();
        do_reset();
        grp_valid = 1;
        for (int k = 0; k < 4; k++) begin
            rob_base = 6'(2 * k); set_slot(1, 1, 0, 1, 0, 0, 0);
            tick();
            checks++; if (ren_valid !== 1'b1 || ren_ckpt !== 2'(k)) begin
                errors++; $display("FAIL fill_ck%0d got v=%0d ck=%0d want %0d", k, ren_valid, ren_ckpt, k); end
        end
        checks++; if (ckpt_free !== 3'd0) begin errors++; $display("FAIL full_free got %0d want 0", ckpt_free); end
        rob_base = 8;
        #1;
        checks++; if (grp_ready !== 1'b0) begin errors++; $display("FAIL full_stall got %0d want 0", grp_ready); end
        tick();
        checks++; if (ren_valid !== 1'b0) begin errors++; $display("FAIL full_stall_valid got %0d want 0", ren_valid); end
        set_slot(1, 1, 0, 0, 0, 0, 0);
        #1;
        checks++; if (grp_ready !== 1'b1) begin errors++; $display("FAIL nonbr_ready got %0d want 1", grp_ready); end
        tick();
        checks++; if (ren_valid !== 1'b1) begin errors++; $display("FAIL nonbr_valid got %0d want 1", ren_valid); end
        grp_valid = 0; res_val = 1; res_ckpt = 2; res_mispred = 0;
        tick();
        checks++; if (ckpt_free !== 3'd1) begin errors++; $display("FAIL release_free got %0d want 1", ckpt_free); end
        res_val = 0; grp_valid = 1; rob_base = 10; set_slot(1, 1, 0, 1, 0, 0, 0);
        tick();
        checks++; if (ren_ckpt !== 2'd2 || ckpt_free !== 3'd0) begin
            errors++; $display("FAIL reuse got ck=%0d free=%0d want ck=2 free=0", ren_ckpt, ckpt_free); end
        grp_valid = 0; res_val = 1; res_ckpt = 0;
        tick();
        grp_valid = 1; rob_base = 12; res_ckpt = 3;
        tick();
        checks++; if (ren_ckpt !== 2'd0 || ckpt_free !== 3'd1) begin
            errors++; $display("FAIL alloc_and_release got ck=%0d free=%0d want ck=0 free=1", ren_ckpt, ckpt_free); end
        res_val = 0;
    endtask

    task automatic test_age();
        do_reset();
        grp_valid = 1; rob_head = 60;
        rob_base = 62; set_slot(0, 1, 0, 1, 0, 0, 0); tick();
        rob_base = 1;  tick();
        rob_base = 3;  tick();
        checks++; if (ren_ckpt !== 2'd2 || ckpt_free !== 3'd1) begin
            errors++; $display("FAIL age_fill got ck=%0d free=%0d want ck=2 free=1", ren_ckpt, ckpt_free); end
        grp_valid = 0; res_val = 1; res_ckpt = 1; res_mispred = 1;
        tick();
        checks++; if (ckpt_free !== 3'd3) begin errors++; $display("FAIL age_flush got %0d want 3", ckpt_free); end
        res_val = 0; grp_valid = 1; rob_base = 5;
        tick();
        checks++; if (ren_ckpt !== 2'd1 || ckpt_free !== 3'd2) begin
            errors++; $display("FAIL age_survivor got ck=%0d free=%0d want ck=1 free=2", ren_ckpt, ckpt_free); end
        grp_valid = 0; res_val = 1; res_ckpt = 0; res_mispred = 1;
        tick();
        checks++; if (ckpt_free !== 3'd4) begin errors++; $display("FAIL age_wrap_flush got %0d want 4", ckpt_free); end
        res_val = 0;
    endtask

    task automatic test_midreset();
        grp_valid = 1; rob_base = 30; set_slot(0, 1, 1, 1, 9, 0, 0);
        rst = 1;
        tick();
        rst = 0; clear_inputs();
        checks++; if (ren_valid !== 1'b0 || ckpt_free !== 3'd4 || grp_ready !== 1'b1) begin
            errors++; $display("FAIL midreset got v=%0d free=%0d rdy=%0d want 0 4 1", ren_valid, ckpt_free, grp_ready); end
        grp_valid = 1; set_slot(0, 1, 0, 0, 0, 9, 0);
        tick();
        checks++; if (ren_inrob[0][0] !== 1'b0 || ren_tag[0][0] !== 6'd0) begin
            errors++; $display("FAIL midreset_table got {%0d,%0d} want {0,0}", ren_inrob[0][0], ren_tag[0][0]); end
    endtask

    task automatic test_random();
        int rb = 0;
        int bs, r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            grp_valid = ($urandom_range(0, 3) != 0);
            rob_base  = 6'(rb);
            rob_head  = 6'((rb + 64 - 20) % 64);
            bs = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1) : -1;
            for (int i = 0; i < 2; i++)
                set_slot(i, (i == bs) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         (i == bs), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            for (int p = 0; p < 2; p++) begin
                r = $urandom_range(0, 7);
                ret_val[p] = 1'($urandom_range(0, 1));
                ret_wr[p]  = ($urandom_range(0, 3) != 0);
                ret_rd[p]  = 5'(r);
                ret_robid[p] = ($urandom_range(0, 3) != 0) ? 6'(m_tg[r]) : 6'($urandom_range(0, 63));
                if (ret_robid[p] == 6'(rb) || ret_robid[p] == 6'((rb + 1) % 64)) ret_val[p] = 0;
            end
            res_val = ($urandom_range(0, 5) == 0);
            res_ckpt = 2'($urandom_range(0, 3));
            res_mispred = 1'($urandom_range(0, 1));
            tick();
            if (e_valid) rb = (rb + 2) % 64;
            checks++; if (obs_ready !== e_ready) begin errors++; $display("FAIL rand_ready c%0d got %0d want %0d", c, obs_ready, e_ready); end
            checks++; if (ren_valid !== e_valid) begin errors++; $display("FAIL rand_valid c%0d got %0d want %0d", c, ren_valid, e_valid); end
            checks++; if (ckpt_free !== 3'(free_cnt())) begin errors++; $display("FAIL rand_free c%0d got %0d want %0d", c, ckpt_free, free_cnt()); end
            checks++; if (ren_ckpt !== 2'(e_ck)) begin errors++; $display("FAIL rand_ckpt c%0d got %0d want %0d", c, ren_ckpt, e_ck); end
            for (int i = 0; i < 2; i++) for (int s = 0; s < 2; s++) begin
                checks++;
                if (ren_inrob[i][s] !== 1'(e_in[i][s]) || ren_tag[i][s] !== 6'(e_tg[i][s])) begin
                    errors++;
                    $display("FAIL rand_src c%0d slot%0d src%0d got {%0d,%0d} want {%0d,%0d}",
                             c, i, s, ren_inrob[i][s], ren_tag[i][s], e_in[i][s], e_tg[i][s]);
                end
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_bypass();
        test_retire_override();
        test_mispredict();
        test_ckpt_full();
        test_age();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ckpt_rat.md
CKPT_RAT -- requirements
Module: ckpt_rat

Interface
REQ-001 Parameter ARCH_REGS, default 32: number of architectural registers; x0 is never renamed.
REQ-002 Parameter ISSUE_W, default 2: rename slots per group.
REQ-003 Parameter RET_W, default 2: retire ports.
REQ-004 Parameter ROB_DEPTH, default 64: ROB entries; ROB_W = clog2(ROB_DEPTH).
REQ-005 Parameter NUM_CKPT, default 4: branch checkpoints; CK_W = clog2(NUM_CKPT).
REQ-006 Ports, one per line:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- grp_valid  in  1  rename group present.
- grp_ready  out  1  group accepted when grp_valid & grp_ready.
- slot_val  in  ISSUE_W  per-slot valid.
- slot_wr  in  ISSUE_W  slot writes rd.
- slot_br  in  ISSUE_W  slot needs a checkpoint; at most one set per group (upstream guarantee).
- rd, rs1, rs2  in  ISSUE_W x 5  architectural indices.
- rob_base  in  ROB_W  robid of slot 0; slot i gets (rob_base+i) mod ROB_DEPTH.
- rob_head  in  ROB_W  oldest in-flight robid, used for age compare.
- ret_val  in  RET_W  retire valid.
- ret_wr  in  RET_W  retiring instruction wrote rd.
- ret_rd  in  RET_W x 5  retiring rd.
- ret_robid  in  RET_W x ROB_W  retiring robid.
- res_val  in  1  branch resolve.
- res_ckpt  in  CK_W  checkpoint resolved.
- res_mispred  in  1  1: restore; 0: release.
- ren_valid  out  1  renamed group valid.
- ren_tag  out  ISSUE_W x 2 x ROB_W  source tag (src0 = rs1, src1 = rs2).
- ren_inrob  out  ISSUE_W x 2  1: value in ROB at tag; 0: read PRF.
- ren_ckpt  out  CK_W  checkpoint given to the branch slot.
- ckpt_free  out  CK_W+1  count of free checkpoints.

Function
REQ-007 Entry is {inrob, tag}; x0 always reads {0,0} and is never written.
REQ-008 Lookup reads the table before the group's writes; 1-cycle latency; outputs registered; ren_valid pulses the cycle after acceptance.
REQ-009 Intra-group bypass: a source of slot i matching rd of the youngest older slot j<i with slot_val & slot_wr gets {1, rob_base+j}.
REQ-010 Issue write: each accepted valid writing slot sets table[rd] = {1, robid}; for the same rd the youngest slot wins.
REQ-011 Retire clear: for each ret_val & ret_wr with table[ret_rd] == {1, ret_robid}, set inrob = 0; tag is kept.
REQ-012 An issue write to the same rd in the same cycle overrides a retire clear.
REQ-013 grp_ready = ~(any slot_br & ckpt_free==0) & ~(res_val & res_mispred).
REQ-014 Checkpoint allocation: when an accepted group has slot_br[b], take the lowest-index free checkpoint.
- Snapshot = table with slot 0..b writes applied.
- Store robid of slot b; mark valid; drive ren_ckpt.
REQ-015 Each retire clear (REQ-011 rule) also applies to every valid checkpoint entry, including one allocated that cycle.
REQ-016 Resolve, res_mispred=0: free res_ckpt only.
REQ-017 Resolve, res_mispred=1:
- Copy the checkpoint into the table, with that cycle's retire clears applied.
- Free it and every valid checkpoint whose (robid-rob_head) mod ROB_DEPTH is larger.
- Ignore the same-cycle issue group.
REQ-018 A resolve to an invalid checkpoint has no effect.
REQ-019 Allocation and release in the same cycle: ckpt_free reflects both on the next cycle; the released entry is not reused that cycle.
REQ-020 robid arithmetic wraps modulo ROB_DEPTH.

Reset
REQ-021 rst: every table entry {0,0}; all checkpoints invalid; ckpt_free=NUM_CKPT; ren_valid=0; ren_tag, ren_inrob, ren_ckpt = 0.
REQ-022 rst mid-operation overrides issue, retire and resolve in that cycle; grp_ready=1 in the first cycle after reset.

Structure
REQ-023 Shared package holds the entry struct (inrob, tag), the checkpoint struct (valid, robid, table snapshot) and the age-compare function.
REQ-024 One sub-module, ckpt_age_cmp: per-checkpoint younger-than mask from rob_head; the rest is flat RTL.

Verification
REQ-025 Reset, then one group with rs1=5 -> next cycle {inrob=0, tag=0}, ckpt_free=4.
REQ-026 Slot0 rd=3 and slot1 rs1=3, rob_base=10 -> slot1 src0 {1,10}; the next group reading x3 gets {1,10}.
REQ-027 Same-cycle issue rd=7 (robid 12) and retire rd=7 robid 4 -> table[7]={1,12}; retire of robid 12 alone -> {0,12}.
REQ-028 Branch at robid 20 takes ckpt 0, later writes to x8; mispredict ckpt 0 -> x8 restored; grp_ready=0 that cycle.
REQ-029 Four branches fill all checkpoints -> ckpt_free=0; a branch group stalls; a non-branch group is accepted; release of ckpt 2 -> next branch takes ckpt 2.
REQ-030 Checkpoints at robids 62, 1, 3 with rob_head=60; mispredict on robid 1 -> robids 1 and 3 freed, 62 stays valid.
